mmio_gpio_bank: RTL and testbench
=================================

Name: mmio_gpio_bank

Overview:
- Parametrised memory-mapped I/O bank replacing the single fixed 8-bit in/out port pair at 0x800.
- Provides NCH independent channels of WIDTH bits each. Every channel has:
  - a registered output latch,
  - a two-flop synchronised input,
  - sticky rising-edge status with write-1-to-clear,
  - a per-bit interrupt enable.
- Sits beside dmem on the single-cycle core's data bus. The top level uses hit to steer rdata into ReadData instead of the memory data.

Parameters:
- NCH, 2, number of channels (1..16).
- WIDTH, 8, bits per channel (1..32).
- BASE, 32'h800, byte address of channel 0. Must be 16-byte aligned.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- we  in  1  bus write strobe (core MemWrite).
- adr  in  32  bus byte address (core ALUResult).
- wdata  in  32  bus write data.
- rdata  out  32  combinational read data, zero-extended from WIDTH.
- hit  out  1  combinational: adr falls inside this bank's window.
- pins_in  in  NCH*WIDTH  asynchronous external inputs; channel n occupies bits [n*WIDTH +: WIDTH].
- pins_out  out  NCH*WIDTH  registered outputs, same packing.
- irq  out  1  registered-state-derived interrupt request, level.

Behaviour:
- Window: BASE <= adr < BASE + NCH*16.
  - hit = 1 inside the window, else 0.
  - Outside the window: rdata = 0 and writes are ignored.
- Decode:
  - ch = (adr - BASE) >> 4.
  - Register offset = adr[3:2].
  - adr[1:0] is ignored (word access only).
- Register map per channel (offset, access):
  - 0x0 OUT, RW: drives pins_out.
  - 0x4 IN, RO: synchronised pin value. Writes are ignored.
  - 0x8 STAT, R/W1C: sticky rising-edge flags.
  - 0xC IEN, RW: interrupt enable per bit.
- Writes:
  - Take effect at the clk edge where we & hit.
  - Use wdata[WIDTH-1:0]; upper bits are discarded.
- Reads:
  - Purely combinational with no side effects. The single-cycle core samples rdata in the same cycle.
  - rdata = {(32-WIDTH) zeros, reg}.
- Input path, per bit: sync1 <= pin; sync2 <= sync1; prev <= sync2.
  - IN reads sync2.
  - edge = sync2 & ~prev.
- Latency, for a pin change that is stable before clk edge k:
  - Visible on IN after edge k+1.
  - STAT bit set after edge k+2.
  - irq asserted after edge k+2 if the bit is enabled.
- STAT update per bit: next = (STAT & ~clr) | edge.
  - clr = wdata bit when writing offset 0x8 of this channel.
  - A simultaneous edge and clear leaves the bit set (set wins).
- irq = OR over all channels and bits of (STAT & IEN). It is combinational from registers and glitch-free relative to clk.
- Reset, asynchronous, at any time including mid-write:
  - OUT, IEN, STAT, sync1, sync2 and prev all = 0.
  - pins_out = 0, irq = 0.
  - A high pin seen after reset release produces a STAT edge at the third clk edge. This is intended.
- Writing OUT does not affect IN/STAT. Loopback is observed only through the external pins.
- NCH = 1 is valid: the window is 16 bytes and ch is always 0.

Decomposition:
- Package gpio_pkg:
  - localparams for the register offsets (OFF_OUT=2'd0, OFF_IN=2'd1, OFF_STAT=2'd2, OFF_IEN=2'd3).
  - CH_STRIDE = 16.
  - An enum typedef for the offset field.
- Sub-module gpio_channel #(WIDTH):
  - Holds OUT/IEN/STAT/synchroniser for one channel.
  - Ports: clk, reset, wr_en, wr_off, wdata, pin_in, pin_out, rd_off, rd_data, irq_ch.
- mmio_gpio_bank contains:
  - the window compare,
  - the channel index decode,
  - a generate loop of NCH instances,
  - the read mux,
  - the irq OR-reduce.

Test Plan:
1. Reset value check: with reset asserted, drive pins_in = all 1s → pins_out = 0, irq = 0, and a read of 0x800/0x808 gives rdata = 0. Release reset → STAT reads 0xFF after the third edge.
2. Output write: we=1, adr=0x810, wdata=0x1234_56A5 → after one edge, pins_out[15:8] = 0xA5 and pins_out[7:0] unchanged. A read of 0x810 returns 0x0000_00A5 with hit = 1.
3. Input latency: pins_in[7:0] goes 0x00→0x3C before edge k → IN (0x804) reads 0x00 until edge k+1, then 0x3C. STAT (0x808) reads 0x3C after edge k+2.
4. W1C and race: with STAT = 0x3C, write 0x808 ← 0x0C while a new rising edge occurs on bit 2 that same cycle → STAT = 0x34 (bit 3 cleared, bit 2 stays set).
5. Interrupt: write IEN 0x80C ← 0x01, then pulse pins_in[0] high → irq = 1 after edge k+2. Write 0x808 ← 0x01 with the pin still high → irq = 0, and no re-set because there is no new edge.
6. Out-of-window access: adr=0x820 (NCH=2) or 0x7FC, we=1, wdata=0xFF → hit = 0, rdata = 0, all registers unchanged. A write to IN at 0x804 is also ignored.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared definitions for the memory-mapped GPIO bank: register offsets and channel stride.
package gpio_pkg;

  localparam logic [1:0] OFF_OUT  = 2'd0;
  localparam logic [1:0] OFF_IN   = 2'd1;
  localparam logic [1:0] OFF_STAT = 2'd2;
  localparam logic [1:0] OFF_IEN  = 2'd3;

  localparam int CH_STRIDE = 16;

  typedef enum logic [1:0] {
    REG_OUT  = OFF_OUT,
    REG_IN   = OFF_IN,
    REG_STAT = OFF_STAT,
    REG_IEN  = OFF_IEN
  } reg_off_e;

endpackage

// File: rtl/gpio_channel.sv
// One GPIO channel: output latch, two-flop input synchroniser, sticky rising-edge
// status (write-1-to-clear) and per-bit interrupt enable.
module gpio_channel
  import gpio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       wr_off,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  input  logic [1:0]       rd_off,
  output logic [WIDTH-1:0] rd_data,
  output logic             irq_ch
);

  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] ien_r;
  logic [WIDTH-1:0] stat_r;
  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] prev_r;

  logic [WIDTH-1:0] out_nxt_s;
  logic [WIDTH-1:0] ien_nxt_s;
  logic [WIDTH-1:0] stat_nxt_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] edge_s;
  reg_off_e         wr_sel_s;
  reg_off_e         rd_sel_s;

  assign wr_sel_s = reg_off_e'(wr_off);
  assign rd_sel_s = reg_off_e'(rd_off);
  assign edge_s   = sync2_r & ~prev_r;

  // Register write decode; a same-cycle edge beats a clear.
  always_comb begin
    out_nxt_s = out_r;
    ien_nxt_s = ien_r;
    clr_s     = {WIDTH{1'b0}};
    if (wr_en) begin
      case (wr_sel_s)
        REG_OUT:  out_nxt_s = wdata;
        REG_IN:   clr_s     = {WIDTH{1'b0}};
        REG_STAT: clr_s     = wdata;
        REG_IEN:  ien_nxt_s = wdata;
        default:  clr_s     = {WIDTH{1'b0}};
      endcase
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    stat_nxt_s = (stat_r & ~clr_s) | edge_s;
  end

  // State registers and input synchroniser chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_r   <= {WIDTH{1'b0}};
      ien_r   <= {WIDTH{1'b0}};
      stat_r  <= {WIDTH{1'b0}};
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
      prev_r  <= {WIDTH{1'b0}};
    end else begin
      out_r   <= out_nxt_s;
      ien_r   <= ien_nxt_s;
      stat_r  <= stat_nxt_s;
      sync1_r <= pin_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Side-effect-free read selection.
  always_comb begin
    case (rd_sel_s)
      REG_OUT:  rd_data = out_r;
      REG_IN:   rd_data = sync2_r;
      REG_STAT: rd_data = stat_r;
      REG_IEN:  rd_data = ien_r;
      default:  rd_data = {WIDTH{1'b0}};
    endcase
  end

  assign pin_out = out_r;
  assign irq_ch  = |(stat_r & ien_r);

endmodule

// File: rtl/mmio_gpio_bank.sv
// Memory-mapped bank of NCH GPIO channels sitting beside dmem; hit steers rdata
// onto the core's read path.
module mmio_gpio_bank
  import gpio_pkg::*;
#(
  parameter int          NCH   = 2,
  parameter int          WIDTH = 8,
  parameter logic [31:0] BASE  = 32'h0000_0800
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [31:0]          adr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 hit,
  input  logic [NCH*WIDTH-1:0] pins_in,
  output logic [NCH*WIDTH-1:0] pins_out,
  output logic                 irq
);

  localparam int          CH_W      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int          CH_SHIFT  = $clog2(CH_STRIDE);
  localparam logic [31:0] WIN_BYTES = 32'(NCH * CH_STRIDE);

  logic [31:0]      offset_s;
  logic             hit_s;
  logic [CH_W-1:0]  ch_idx_s;
  logic [NCH-1:0]   wr_en_s;
  logic [NCH-1:0]   irq_ch_s;
  logic [WIDTH-1:0] rd_data_s [NCH];
  logic [WIDTH-1:0] rd_mux_s;
  logic             unused_s;

  // Subtracting first keeps the upper bound free of overflow near the top of memory.
  assign offset_s = adr - BASE;
  assign hit_s    = (adr >= BASE) && (offset_s < WIN_BYTES);
  assign ch_idx_s = offset_s[CH_SHIFT +: CH_W];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign wr_en_s[g] = we && hit_s && (ch_idx_s == CH_W'(g));

    gpio_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en_s[g]),
      .wr_off  (adr[3:2]),
      .wdata   (wdata[WIDTH-1:0]),
      .pin_in  (pins_in[g*WIDTH +: WIDTH]),
      .pin_out (pins_out[g*WIDTH +: WIDTH]),
      .rd_off  (adr[3:2]),
      .rd_data (rd_data_s[g]),
      .irq_ch  (irq_ch_s[g])
    );
  end

  // Channel read mux; anything outside the window reads as zero.
  always_comb begin
    rd_mux_s = {WIDTH{1'b0}};
    for (int n = 0; n < NCH; n++) begin
      rd_mux_s = (hit_s && (ch_idx_s == CH_W'(n))) ? rd_data_s[n] : rd_mux_s;
    end
  end

  assign rdata    = 32'(rd_mux_s);
  assign hit      = hit_s;
  assign irq      = |irq_ch_s;
  assign unused_s = ^{adr[1:0], wdata, offset_s};

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// Self-checking bench for mmio_gpio_bank: directed scenarios plus randomized traffic
// against a pin-history reference model.
module tb_mmio_gpio_bank;

  localparam int          NCH   = 2;
  localparam int          WIDTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_0800;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 we;
  logic [31:0]          adr;
  logic [31:0]          wdata;
  logic [31:0]          rdata;
  logic                 hit;
  logic [NCH*WIDTH-1:0] pins_in;
  logic [NCH*WIDTH-1:0] pins_out;
  logic                 irq;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mmio_gpio_bank #(.NCH(NCH), .WIDTH(WIDTH), .BASE(BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .adr      (adr),
    .wdata    (wdata),
    .rdata    (rdata),
    .hit      (hit),
    .pins_in  (pins_in),
    .pins_out (pins_out),
    .irq      (irq)
  );

  // Reference model: registers per channel plus the pin values sampled 1, 2 and 3 edges ago.
  logic [WIDTH-1:0]     out_m  [NCH];
  logic [WIDTH-1:0]     ien_m  [NCH];
  logic [WIDTH-1:0]     stat_m [NCH];
  logic [NCH*WIDTH-1:0] h0, h1, h2;

  function automatic logic m_hit(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(NCH * 16));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int c;
    logic [WIDTH-1:0] v;
    if (!m_hit(a)) return 32'd0;
    c = int'((a - BASE) >> 4);
    case (a[3:2])
      2'd0:    v = out_m[c];
      2'd1:    v = h1[c*WIDTH +: WIDTH];
      2'd2:    v = stat_m[c];
      default: v = ien_m[c];
    endcase
    return 32'(v);
  endfunction

  function automatic logic [NCH*WIDTH-1:0] m_pins_out();
    logic [NCH*WIDTH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*WIDTH +: WIDTH] = out_m[c];
    return v;
  endfunction

  function automatic logic m_irq();
    logic r = 1'b0;
    for (int c = 0; c < NCH; c++) r = r | (|(stat_m[c] & ien_m[c]));
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      out_m[c] = '0; ien_m[c] = '0; stat_m[c] = '0;
    end
    h0 = '0; h1 = '0; h2 = '0;
  endtask

  // A pin rising between samples 3 and 2 edges ago shows up in STAT at this edge.
  task automatic model_edge();
    logic [WIDTH-1:0] e, clr;
    int ch;
    logic wr;
    wr = we && m_hit(adr);
    ch = int'((adr - BASE) >> 4);
    for (int c = 0; c < NCH; c++) begin
      e = h1[c*WIDTH +: WIDTH] & ~h2[c*WIDTH +: WIDTH];
      clr = '0;
      if (wr && ch == c) begin
        case (adr[3:2])
          2'd0:    out_m[c] = wdata[WIDTH-1:0];
          2'd2:    clr = wdata[WIDTH-1:0];
          2'd3:    ien_m[c] = wdata[WIDTH-1:0];
          default: ;
        endcase
      end
      stat_m[c] = (stat_m[c] & ~clr) | e;
    end
    h2 = h1; h1 = h0; h0 = pins_in;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; we = 1'b0; adr = 32'd0; wdata = 32'd0; pins_in = '1;
    model_reset();
    repeat (3) step();
    total_cnt++; if (pins_out !== '0) $display("FAIL reset_pins_out: got %h want 0", pins_out); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else pass_cnt++;
    adr = 32'h800; #1;
    total_cnt++; if (rdata !== 32'd0) $display("FAIL reset_rd_800: got %h want 0", rdata); else pass_cnt++;
    adr = 32'h808; #1;
    total_cnt++; if (rdata !== 32'd0) $display("FAIL reset_rd_808: got %h want 0", rdata); else pass_cnt++;
    reset = 1'b0;
    step(); step();
    total_cnt++; if (rdata !== 32'd0) $display("FAIL reset_stat_edge2: got %h want 0", rdata); else pass_cnt++;
    step();
    total_cnt++; if (rdata !== 32'hFF) $display("FAIL reset_stat_edge3: got %h want ff", rdata); else pass_cnt++;
    adr = 32'h818; #1;
    total_cnt++; if (rdata !== 32'hFF) $display("FAIL reset_stat_ch1: got %h want ff", rdata); else pass_cnt++;
  endtask

  task automatic test_out_write();
    logic [7:0] lo;
    lo = pins_out[7:0];
    we = 1'b1; adr = 32'h810; wdata = 32'h1234_56A5;
    step();
    we = 1'b0; #1;
    total_cnt++; if (pins_out[15:8] !== 8'hA5) $display("FAIL out_ch1: got %h want a5", pins_out[15:8]); else pass_cnt++;
    total_cnt++; if (pins_out[7:0] !== lo) $display("FAIL out_ch0_kept: got %h want %h", pins_out[7:0], lo); else pass_cnt++;
    total_cnt++; if (rdata !== 32'h0000_00A5) $display("FAIL out_readback: got %h want a5", rdata); else pass_cnt++;
    total_cnt++; if (hit !== 1'b1) $display("FAIL out_hit: got %b want 1", hit); else pass_cnt++;
  endtask

  task automatic test_input_latency();
    pins_in[7:0] = 8'h00;
    repeat (3) step();
    we = 1'b1; adr = 32'h808; wdata = 32'hFF;
    step();
    we = 1'b0; #1;
    total_cnt++; if (rdata !== 32'd0) $display("FAIL lat_stat_clean: got %h want 0", rdata); else pass_cnt++;
    pins_in[7:0] = 8'h3C;
    step();
    adr = 32'h804; #1;
    total_cnt++; if (rdata !== 32'd0) $display("FAIL lat_in_k: got %h want 0", rdata); else pass_cnt++;
    step();
    total_cnt++; if (rdata !== 32'h3C) $display("FAIL lat_in_k1: got %h want 3c", rdata); else pass_cnt++;
    adr = 32'h808; #1;
    total_cnt++; if (rdata !== 32'd0) $display("FAIL lat_stat_k1: got %h want 0", rdata); else pass_cnt++;
    step();
    total_cnt++; if (rdata !== 32'h3C) $display("FAIL lat_stat_k2: got %h want 3c", rdata); else pass_cnt++;
  endtask

  task automatic test_w1c_race();
    pins_in[7:0] = 8'h38;
    repeat (3) step();
    adr = 32'h808; #1;
    total_cnt++; if (rdata !== 32'h3C) $display("FAIL w1c_sticky: got %h want 3c", rdata); else pass_cnt++;
    pins_in[7:0] = 8'h3C;
    step(); step();
    we = 1'b1; adr = 32'h808; wdata = 32'h0C;
    step();
    we = 1'b0; #1;
    total_cnt++; if (rdata !== 32'h34) $display("FAIL w1c_race: got %h want 34", rdata); else pass_cnt++;
    total_cnt++; if (rdata !== m_read(32'h808)) $display("FAIL w1c_model: got %h want %h", rdata, m_read(32'h808)); else pass_cnt++;
  endtask

  task automatic test_irq();
    we = 1'b1; adr = 32'h80C; wdata = 32'h01;
    step();
    we = 1'b0;
    total_cnt++; if (irq !== 1'b0) $display("FAIL irq_idle: got %b want 0", irq); else pass_cnt++;
    pins_in[0] = 1'b1;
    step(); step();
    total_cnt++; if (irq !== 1'b0) $display("FAIL irq_k1: got %b want 0", irq); else pass_cnt++;
    step();
    total_cnt++; if (irq !== 1'b1) $display("FAIL irq_k2: got %b want 1", irq); else pass_cnt++;
    we = 1'b1; adr = 32'h808; wdata = 32'h01;
    step();
    we = 1'b0;
    total_cnt++; if (irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq); else pass_cnt++;
    repeat (3) step();
    total_cnt++; if (irq !== 1'b0) $display("FAIL irq_no_reset: got %b want 0", irq); else pass_cnt++;
  endtask

  task automatic test_out_of_window();
    logic [31:0] addrs [5];
    addrs = '{32'h820, 32'h7FC, 32'h83C, 32'h0, 32'hFFFF_FFFC};
    foreach (addrs[i]) begin
      we = 1'b1; adr = addrs[i]; wdata = 32'hFF; #1;
      total_cnt++; if (hit !== 1'b0) $display("FAIL oow_hit %h: got %b want 0", adr, hit); else pass_cnt++;
      total_cnt++; if (rdata !== 32'd0) $display("FAIL oow_rdata %h: got %h want 0", adr, rdata); else pass_cnt++;
      step();
    end
    we = 1'b1; adr = 32'h804; wdata = 32'hFF;
    step();
    we = 1'b0;
    for (int a = 0; a < NCH * 16; a += 4) begin
      adr = BASE + 32'(a); #1;
      total_cnt++; if (rdata !== m_read(adr)) $display("FAIL oow_regs %h: got %h want %h", adr, rdata, m_read(adr)); else pass_cnt++;
    end
    total_cnt++; if (pins_out !== m_pins_out()) $display("FAIL oow_pins_out: got %h want %h", pins_out, m_pins_out()); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 63) == 0) begin
        #1 reset = 1'b1; #1;
        model_reset();
        total_cnt++; if (pins_out !== '0) $display("FAIL rnd_reset_pins: got %h want 0", pins_out); else pass_cnt++;
        total_cnt++; if (irq !== 1'b0) $display("FAIL rnd_reset_irq: got %b want 0", irq); else pass_cnt++;
        reset = 1'b0;
      end
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) adr = 32'h7F0 + 32'($urandom_range(0, 63));
      else adr = BASE + 32'($urandom_range(0, NCH - 1) * 16 + $urandom_range(0, 15));
      wdata = $urandom;
      if ($urandom_range(0, 2) == 0) pins_in = (NCH*WIDTH)'($urandom);
      #1;
      total_cnt++; if (hit !== m_hit(adr)) $display("FAIL rnd_hit %h: got %b want %b", adr, hit, m_hit(adr)); else pass_cnt++;
      total_cnt++; if (rdata !== m_read(adr)) $display("FAIL rnd_rdata %h: got %h want %h", adr, rdata, m_read(adr)); else pass_cnt++;
      total_cnt++; if (pins_out !== m_pins_out()) $display("FAIL rnd_pins_out: got %h want %h", pins_out, m_pins_out()); else pass_cnt++;
      total_cnt++; if (irq !== m_irq()) $display("FAIL rnd_irq: got %b want %b", irq, m_irq()); else pass_cnt++;
      step();
    end
    we = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_out_write();
    test_input_latency();
    test_w1c_race();
    test_irq();
    test_out_of_window();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
